// File: rtl/ps2_move_encoder_pkg.sv
// Shared types and constants for the PS/2 move encoder: move codes,
// receiver states, scan codes and the key-to-move lookup.
package ps2_move_encoder_pkg;

    typedef enum logic [2:0] {
        MOVE_NONE  = 3'd0,
        MOVE_UP    = 3'd1,
        MOVE_DOWN  = 3'd2,
        MOVE_LEFT  = 3'd3,
        MOVE_RIGHT = 3'd4,
        MOVE_PLAY  = 3'd5,
        MOVE_RESET = 3'd6
    } move_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_PREFIX_E0 = 8'hE0;
    localparam logic [7:0] SC_BREAK_F0  = 8'hF0;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_R         = 8'h2D;
    localparam logic [7:0] SC_ARROW_UP  = 8'h75;
    localparam logic [7:0] SC_ARROW_DN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RT  = 8'h74;

    // Key is {e0_seen, scan byte}; the MSB separates arrows from plain keys.
    function automatic move_t map_key(input logic [8:0] key);
        move_t result;
        case (key)
            {1'b1, SC_ARROW_UP}, {1'b0, SC_W}: result = MOVE_UP;
            {1'b1, SC_ARROW_DN}, {1'b0, SC_S}: result = MOVE_DOWN;
            {1'b1, SC_ARROW_LT}, {1'b0, SC_A}: result = MOVE_LEFT;
            {1'b1, SC_ARROW_RT}, {1'b0, SC_D}: result = MOVE_RIGHT;
            {1'b0, SC_SPACE}:                  result = MOVE_PLAY;
            {1'b0, SC_R}:                      result = MOVE_RESET;
            default:                           result = MOVE_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ps2_move_encoder_rx.sv
// PS/2 frame receiver: synchronizes the raw pins, detects clock falling
// edges and assembles start/8 data/odd parity/stop frames with a timeout.
module ps2_rx
    import ps2_move_encoder_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   sdata;

    rx_state_t state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_ok;
    logic [TW-1:0] timer;

    // Pins idle high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign sdata = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_ok  <= 1'b0;
            timer      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                timer <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!sdata) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift <= {sdata, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    RX_PARITY: begin
                        parity_ok <= sdata ^ (^shift);
                        state     <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (sdata && parity_ok) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                endcase
            end else if (state != RX_IDLE) begin
                // A stalled partial frame is dropped after the idle window.
                if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err <= 1'b1;
                    state     <= RX_IDLE;
                    timer     <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_move_encoder.sv
// Turns PS/2 make/break scan codes into single-cycle move pulses,
// suppressing typematic repeats of the key currently held down.
module ps2_move_encoder
    import ps2_move_encoder_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] move,
    output logic       frame_err,
    output logic [7:0] key_code
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic [8:0] cur_key;

    move_t      move_q;
    logic       e0_seen;
    logic       f0_seen;
    logic       held_valid;
    logic [8:0] held_key;

    ps2_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign cur_key  = {e0_seen, rx_byte};
    assign key_code = rx_byte;
    assign move     = move_q;

    // held_valid keeps "no key held" distinct from a held scan code of 00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q     <= MOVE_NONE;
            e0_seen    <= 1'b0;
            f0_seen    <= 1'b0;
            held_valid <= 1'b0;
            held_key   <= '0;
        end else begin
            move_q <= MOVE_NONE;
            if (byte_valid) begin
                if (rx_byte == SC_PREFIX_E0) begin
                    e0_seen <= 1'b1;
                end else if (rx_byte == SC_BREAK_F0) begin
                    f0_seen <= 1'b1;
                end else begin
                    e0_seen <= 1'b0;
                    f0_seen <= 1'b0;
                    if (!f0_seen) begin
                        if (!(held_valid && held_key == cur_key)) begin
                            held_valid <= 1'b1;
                            held_key   <= cur_key;
                            move_q     <= map_key(cur_key);
                        end
                    end else if (held_valid && held_key == cur_key) begin
                        held_valid <= 1'b0;
                        held_key   <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_move_encoder.sv
// Directed bench for ps2_move_encoder: table of PS/2 frames with expected
// move/frame_err/key_code, plus timeout, bad-start and mid-frame reset cases.
module tb_ps2_move_encoder;

    localparam int TB_TIMEOUT = 2000;
    localparam int HALF       = 40;

    localparam logic [2:0] M_NONE  = 3'd0;
    localparam logic [2:0] M_UP    = 3'd1;
    localparam logic [2:0] M_DOWN  = 3'd2;
    localparam logic [2:0] M_LEFT  = 3'd3;
    localparam logic [2:0] M_RIGHT = 3'd4;
    localparam logic [2:0] M_PLAY  = 3'd5;
    localparam logic [2:0] M_RESET = 3'd6;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic [2:0] exp_move;
        logic       exp_err;
        logic [7:0] exp_key;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] move;
    logic       frame_err;
    logic [7:0] key_code;

    int   cyc = 0;
    int   pulse_cnt = 0;
    int   err_cnt = 0;
    int   last_pulse_cyc = 0;
    logic [2:0] last_move = 3'd0;
    int   checks = 0;
    int   fails = 0;
    vec_t vecs[$];

    ps2_move_encoder #(
        .TIMEOUT_CYC(TB_TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .move     (move),
        .frame_err(frame_err),
        .key_code (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (move != 3'd0) begin
            pulse_cnt++;
            last_move = move;
            last_pulse_cyc = cyc;
        end
        if (frame_err) err_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic send_bit(input logic b, output int fall_cyc);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic bad_par,
                                 input logic bad_stop, input int nbits,
                                 output int stop_cyc);
        logic [10:0] frame;
        int          fc;
        frame = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        fc = 0;
        for (int b = 0; b < nbits; b++) send_bit(frame[b], fc);
        stop_cyc = fc;
    endtask

    task automatic add_vec(input logic [7:0] data, input logic bad_par,
                           input logic bad_stop, input logic [2:0] exp_move,
                           input logic exp_err, input logic [7:0] exp_key);
        vec_t v;
        v.data = data; v.bad_par = bad_par; v.bad_stop = bad_stop;
        v.exp_move = exp_move; v.exp_err = exp_err; v.exp_key = exp_key;
        vecs.push_back(v);
    endtask

    task automatic clear_counts();
        pulse_cnt = 0;
        err_cnt   = 0;
        last_move = 3'd0;
    endtask

    initial begin
        int stop_cyc;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_move", 32'(move), 32'(M_NONE));
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        checkOutput("reset_key", 32'(key_code), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        //       data   par   stop  move     err   key
        add_vec(8'h29, 1'b0, 1'b0, M_PLAY,  1'b0, 8'h29);
        add_vec(8'h29, 1'b0, 1'b1, M_NONE,  1'b1, 8'h29);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h75, 1'b0, 1'b0, M_UP,    1'b0, 8'h75);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h75, 1'b0, 1'b0, M_NONE,  1'b0, 8'h75);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'hF0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hF0);
        add_vec(8'h75, 1'b0, 1'b0, M_NONE,  1'b0, 8'h75);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h75, 1'b0, 1'b0, M_UP,    1'b0, 8'h75);
        add_vec(8'h1C, 1'b1, 1'b0, M_NONE,  1'b1, 8'h75);
        add_vec(8'h1C, 1'b0, 1'b0, M_LEFT,  1'b0, 8'h1C);
        add_vec(8'h15, 1'b0, 1'b0, M_NONE,  1'b0, 8'h15);
        add_vec(8'hF0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hF0);
        add_vec(8'h15, 1'b0, 1'b0, M_NONE,  1'b0, 8'h15);
        add_vec(8'h1B, 1'b0, 1'b0, M_DOWN,  1'b0, 8'h1B);
        add_vec(8'h23, 1'b0, 1'b0, M_RIGHT, 1'b0, 8'h23);
        add_vec(8'h1D, 1'b0, 1'b0, M_UP,    1'b0, 8'h1D);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h72, 1'b0, 1'b0, M_DOWN,  1'b0, 8'h72);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h6B, 1'b0, 1'b0, M_LEFT,  1'b0, 8'h6B);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h74, 1'b0, 1'b0, M_RIGHT, 1'b0, 8'h74);
        add_vec(8'h2D, 1'b0, 1'b0, M_RESET, 1'b0, 8'h2D);
        add_vec(8'hF0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hF0);
        add_vec(8'h2D, 1'b0, 1'b0, M_NONE,  1'b0, 8'h2D);
        add_vec(8'hE0, 1'b0, 1'b0, M_NONE,  1'b0, 8'hE0);
        add_vec(8'h33, 1'b1, 1'b0, M_NONE,  1'b1, 8'hE0);
        add_vec(8'h75, 1'b0, 1'b0, M_UP,    1'b0, 8'h75);

        foreach (vecs[i]) begin
            clear_counts();
            applyStimulus(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11, stop_cyc);
            repeat (12) @(negedge clk);
            checkOutput($sformatf("v%0d_pulses", i), 32'(pulse_cnt),
                        (vecs[i].exp_move != M_NONE) ? 32'd1 : 32'd0);
            checkOutput($sformatf("v%0d_err", i), 32'(err_cnt), 32'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_key", i), 32'(key_code), 32'(vecs[i].exp_key));
            if (vecs[i].exp_move != M_NONE) begin
                checkOutput($sformatf("v%0d_move", i), 32'(last_move), 32'(vecs[i].exp_move));
                checkOutput($sformatf("v%0d_latency", i), 32'(last_pulse_cyc), 32'(stop_cyc + 4));
            end
        end

        // Stray falling edge with data high while idle is a bad start bit.
        clear_counts();
        send_bit(1'b1, stop_cyc);
        repeat (12) @(negedge clk);
        checkOutput("badstart_err", 32'(err_cnt), 32'd1);
        checkOutput("badstart_pulses", 32'(pulse_cnt), 32'd0);

        // Partial frame left hanging until the timeout fires.
        clear_counts();
        applyStimulus(8'h2D, 1'b0, 1'b0, 5, stop_cyc);
        repeat (TB_TIMEOUT / 2) @(negedge clk);
        checkOutput("timeout_early_err", 32'(err_cnt), 32'd0);
        repeat (TB_TIMEOUT) @(negedge clk);
        checkOutput("timeout_err", 32'(err_cnt), 32'd1);
        checkOutput("timeout_pulses", 32'(pulse_cnt), 32'd0);
        clear_counts();
        applyStimulus(8'h2D, 1'b0, 1'b0, 11, stop_cyc);
        repeat (12) @(negedge clk);
        checkOutput("after_timeout_move", 32'(last_move), 32'(M_RESET));
        checkOutput("after_timeout_pulses", 32'(pulse_cnt), 32'd1);
        checkOutput("after_timeout_err", 32'(err_cnt), 32'd0);

        // Hold 23, then reset mid-frame: held must be cleared by reset.
        clear_counts();
        applyStimulus(8'h23, 1'b0, 1'b0, 11, stop_cyc);
        repeat (12) @(negedge clk);
        checkOutput("held23_move", 32'(last_move), 32'(M_RIGHT));
        clear_counts();
        applyStimulus(8'h23, 1'b0, 1'b0, 4, stop_cyc);
        ps2_data = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_move", 32'(move), 32'(M_NONE));
        checkOutput("midreset_err", 32'(frame_err), 32'd0);
        checkOutput("midreset_key", 32'(key_code), 32'h00);
        ps2_data = 1'b1;
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        clear_counts();
        applyStimulus(8'h23, 1'b0, 1'b0, 11, stop_cyc);
        repeat (12) @(negedge clk);
        checkOutput("postreset_move", 32'(last_move), 32'(M_RIGHT));
        checkOutput("postreset_pulses", 32'(pulse_cnt), 32'd1);
        checkOutput("postreset_latency", 32'(last_pulse_cyc), 32'(stop_cyc + 4));
        checkOutput("postreset_err", 32'(err_cnt), 32'd0);
        checkOutput("postreset_key", 32'(key_code), 32'h23);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ps2_move_encoder.md
Name: ps2_move_encoder

Overview:
- Produces the 3-bit `move` command consumed by the game logic block.
- Receives raw PS/2 keyboard frames and decodes make/break scan codes, including the E0-extended arrow keys.
- Issues exactly one single-cycle move pulse per key press; all other cycles carry NONE.
- Sits between the board PS/2 pins and the logic block. It runs on the same 100 MHz clock as the logic block.

Parameters:
- TIMEOUT_CYC, 200000, clk cycles without a PS/2 falling edge before a partial frame is discarded (2 ms at 100 MHz).
- SYNC_STAGES, 2, synchronizer depth for ps2_clk and ps2_data (minimum 2).

Ports:
- clk  input  1  100 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- ps2_data  input  1  raw PS/2 data pin, asynchronous
- move  output  3  move code; NONE except for the single pulse cycle
- frame_err  output  1  one-cycle pulse on a bad start, parity, stop or timeout
- key_code  output  8  last accepted scan byte (debug), held between frames

Behaviour:
- Reset (async, rst_n=0):
  - move=NONE, frame_err=0, key_code=8'h00.
  - Receiver goes to IDLE; e0_seen, f0_seen and held are cleared.
  - Reset asserted mid-frame discards the frame with no pulse.
- Input conditioning:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
  - A falling edge is detected when the synced clock is 1 in the previous cycle and 0 in the current one.
  - Data is sampled only on a detected falling edge.
- Receiver FSM, frame = start(0), 8 data bits LSB first, odd parity, stop(1):
  - IDLE: on a falling edge, if data=0 go to DATA with bit count 0; if data=1, pulse frame_err and stay in IDLE.
  - DATA: shift one bit per edge; after the 8th bit go to PARITY.
  - PARITY: check that data XOR all 8 data bits equals 1; latch the result; go to STOP.
  - STOP: require data=1 and parity OK. Then set byte_valid for 1 cycle, update key_code, and go to IDLE. Otherwise pulse frame_err and go to IDLE.
  - Timeout counter clears on every falling edge and counts while not in IDLE. Reaching TIMEOUT_CYC pulses frame_err and returns to IDLE.
- Decoder, acting on byte_valid:
  - 8'hE0 sets e0_seen.
  - 8'hF0 sets f0_seen.
  - Any other byte forms the key {e0_seen, byte}; e0_seen and f0_seen are then cleared.
- Key map:
  - UP: E0-75 or 1D (W).
  - DOWN: E0-72 or 1B (S).
  - LEFT: E0-6B or 1C (A).
  - RIGHT: E0-74 or 23 (D).
  - PLAY: 29 (space).
  - RESET: 2D (R).
  - All other keys are ignored, with no pulse.
- Make handling (f0_seen=0): if the key equals held, emit nothing (typematic repeat is suppressed). Otherwise load held with the key and emit its move if the key is mapped.
- Break handling (f0_seen=1): if the key equals held, clear held. Never emit a move on break.
- Timing:
  - move is registered and equals the code for exactly 1 cycle.
  - Latency: 2 clk after the cycle in which the stop-bit falling edge is detected.
  - Back-to-back pulses are separated by at least one full frame, so the logic block never sees the same move on consecutive cycles.
- A frame error does not clear e0_seen, f0_seen or held. Only the next valid non-prefix byte consumes the prefix flags.

Decomposition:
- Shared header PARAMS.v:
  - Move codes: NONE, UP, DOWN, LEFT, RIGHT, PLAY, RESET.
  - Scan-code constants for the mapped keys plus E0 and F0.
- Natural sub-module: ps2_rx. It contains the synchronizers, edge detect, receiver FSM and timeout, and outputs byte/byte_valid/frame_err.
- The key decoder and held-key logic stay in ps2_move_encoder.

Test Plan:
- Frame 8'h29, odd parity, ~12.5 kHz PS/2 clock -> move=PLAY for exactly 1 cycle, 2 clk after the stop edge; key_code=8'h29.
- Sequence E0,75 then E0,75 (repeat) then E0,F0,75 -> one UP pulse only; held cleared afterwards. A further E0,75 -> second UP pulse.
- Frame 8'h1C with wrong parity bit -> frame_err pulse, move stays NONE, key_code unchanged.
- 5 bits of a frame then ps2_clk idle for TIMEOUT_CYC -> frame_err pulse; next valid 8'h2D -> RESET pulse.
- rst_n low during bit 4 of frame 8'h23 -> all outputs at reset values; next full 8'h23 -> RIGHT pulse.
- Unmapped make 8'h15 followed by F0,15 -> no move pulse, no frame_err.
